// File: rtl/uut_run_ctrl.sv
// uut_run_ctrl: sequences one cipher UUT run (load key/IV, hold UUT reset, timed run, capture result).
// Define UUT_RUN_CTRL_DEBUG_EN to add debug_o = {state one-hot {fin,run,hold,load} (idle=0), timeout_o, busy, cnt[9:0]}.
module uut_run_ctrl #(
  parameter int KEY_W = 80,
  parameter int IV_W = 80,
  parameter int BLK_W = 64,
  parameter int CNT_W = 32,
  parameter int RST_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [KEY_W-1:0] key_i,
  input  logic [IV_W-1:0]  iv_i,
  input  logic [CNT_W-1:0] timeout_i,
  output logic             busy,
  output logic             done,
  output logic             timeout_o,
  output logic [BLK_W-1:0] block_o,
  output logic [CNT_W-1:0] cycles_o,
  output logic             rst_uut,
  output logic [KEY_W-1:0] key_uut,
  output logic [IV_W-1:0]  iv_uut,
`ifdef UUT_RUN_CTRL_DEBUG_EN
  output logic [15:0]      debug_o,
`endif
  input  logic             end_uut,
  input  logic [BLK_W-1:0] block_o_uut
);
  typedef enum logic [2:0] {IDLE, LOAD, HOLD, RUN, FIN} state_t;
  state_t state_q, state_d;
  logic busy_q, busy_d, done_q, done_d, tmo_q, tmo_d, rst_uut_q, rst_uut_d;
  logic [BLK_W-1:0] block_q, block_d;
  logic [CNT_W-1:0] cycles_q, cycles_d, cnt_q, cnt_d, to_q, to_d, cnt_inc;
  logic [KEY_W-1:0] key_q, key_d;
  logic [IV_W-1:0] iv_q, iv_d;
`ifdef UUT_RUN_CTRL_DEBUG_EN
  logic [15:0] dbg_q, dbg_d;
  assign debug_o = dbg_q;
`endif
  assign busy = busy_q;
  assign done = done_q;
  assign timeout_o = tmo_q;
  assign block_o = block_q;
  assign cycles_o = cycles_q;
  assign rst_uut = rst_uut_q;
  assign key_uut = key_q;
  assign iv_uut = iv_q;
  assign cnt_inc = cnt_q + CNT_W'(1);
  always_comb begin
    state_d = state_q;
    busy_d = busy_q;
    tmo_d = tmo_q;
    block_d = block_q;
    cycles_d = cycles_q;
    key_d = key_q;
    iv_d = iv_q;
    to_d = to_q;
    cnt_d = '0;
    case (state_q)
      IDLE: if (start) begin
        state_d = LOAD;
        busy_d = 1'b1;
        key_d = key_i;
        iv_d = iv_i;
        to_d = timeout_i;
        tmo_d = 1'b0;
        block_d = '0;
        cycles_d = '0;
      end
      LOAD: state_d = HOLD;
      // cnt doubles as the hold counter and is left at zero on RUN entry
      HOLD: begin
        cnt_d = (cnt_q == CNT_W'(RST_CYCLES - 1)) ? '0 : cnt_inc;
        state_d = (cnt_q == CNT_W'(RST_CYCLES - 1)) ? RUN : HOLD;
      end
      RUN: begin
        cnt_d = &cnt_q ? cnt_q : cnt_inc;
        if (end_uut) begin
          block_d = block_o_uut;
          cycles_d = cnt_q;
          state_d = FIN;
        end else if (to_q != '0 && cnt_inc == to_q) begin
          tmo_d = 1'b1;
          cycles_d = to_q;
          state_d = FIN;
        end
      end
      FIN: begin
        busy_d = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    done_d = state_d == FIN;
    rst_uut_d = state_d != RUN;
`ifdef UUT_RUN_CTRL_DEBUG_EN
    dbg_d = {state_d == FIN, state_d == RUN, state_d == HOLD, state_d == LOAD, tmo_d, busy_d, cnt_d[9:0]};
`endif
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      tmo_q <= 1'b0;
      block_q <= '0;
      cycles_q <= '0;
      rst_uut_q <= 1'b1;
      key_q <= '0;
      iv_q <= '0;
      to_q <= '0;
      cnt_q <= '0;
`ifdef UUT_RUN_CTRL_DEBUG_EN
      dbg_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      busy_q <= busy_d;
      done_q <= done_d;
      tmo_q <= tmo_d;
      block_q <= block_d;
      cycles_q <= cycles_d;
      rst_uut_q <= rst_uut_d;
      key_q <= key_d;
      iv_q <= iv_d;
      to_q <= to_d;
      cnt_q <= cnt_d;
`ifdef UUT_RUN_CTRL_DEBUG_EN
      dbg_q <= dbg_d;
`endif
    end
  end
endmodule

// File: tb/tb_uut_run_ctrl.sv
// tb_uut_run_ctrl: directed runs of uut_run_ctrl checked every cycle against a run-age model.
module tb_uut_run_ctrl;
  localparam int R = 4;
  localparam logic [63:0] BASE = 64'hC0DE_F00D_0000_0000;
  logic clk = 0, rst = 1, start = 0, end_uut = 0;
  logic [79:0] key_i = 0, iv_i = 0;
  logic [31:0] timeout_i = 0;
  logic [63:0] blk_in = 0;
  logic busy, done, timeout_o, rst_uut;
  logic [63:0] block_o;
  logic [31:0] cycles_o;
  logic [79:0] key_uut, iv_uut;
  int checks = 0, failures = 0;
  bit chk_en = 0;
`ifdef UUT_RUN_CTRL_DEBUG_EN
  logic [15:0] debug_o;
  logic [3:0] m_oh;
`endif
  // model: m_age counts cycles since start acceptance (-1 when idle); RUN cycle k has m_age = R+1+k
  int m_age = -1;
  bit m_fin = 0, m_busy = 0, m_done = 0, m_tmo = 0, m_rstu = 1;
  logic [63:0] m_blk = 0;
  logic [31:0] m_cyc = 0, m_to = 0;
  logic [79:0] m_key = 0, m_iv = 0;

  uut_run_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .key_i(key_i), .iv_i(iv_i), .timeout_i(timeout_i),
    .busy(busy), .done(done), .timeout_o(timeout_o), .block_o(block_o), .cycles_o(cycles_o),
    .rst_uut(rst_uut), .key_uut(key_uut), .iv_uut(iv_uut),
`ifdef UUT_RUN_CTRL_DEBUG_EN
    .debug_o(debug_o),
`endif
    .end_uut(end_uut), .block_o_uut(blk_in)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [127:0] a, input logic [127:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      if (failures <= 30) $display("FAIL %s actual=%0h required=%0h t=%0t", n, a, e, $time);
    end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      m_age = -1; m_fin = 0; m_busy = 0; m_done = 0; m_tmo = 0; m_rstu = 1;
      m_blk = 0; m_cyc = 0; m_to = 0; m_key = 0; m_iv = 0;
    end else if (m_fin) begin
      m_fin = 0; m_done = 0; m_busy = 0; m_age = -1;
    end else if (m_age < 0) begin
      if (start) begin
        m_age = 0; m_busy = 1; m_tmo = 0; m_blk = 0; m_cyc = 0;
        m_key = key_i; m_iv = iv_i; m_to = timeout_i;
      end
    end else if (m_age >= R + 1 && (end_uut || (m_to != 0 && longint'(m_age - R) == longint'(m_to)))) begin
      m_fin = 1; m_done = 1; m_rstu = 1;
      if (end_uut) begin m_blk = blk_in; m_cyc = 32'(m_age - R - 1); end
      else begin m_tmo = 1; m_cyc = m_to; end
    end else begin
      m_age++;
      m_rstu = m_age < R + 1;
    end
  end

  always @(negedge clk) if (chk_en) begin
    chk("busy", busy, m_busy);
    chk("done", done, m_done);
    chk("timeout_o", timeout_o, m_tmo);
    chk("block_o", block_o, m_blk);
    chk("cycles_o", cycles_o, m_cyc);
    chk("rst_uut", rst_uut, m_rstu);
    chk("key_uut", key_uut, m_key);
    chk("iv_uut", iv_uut, m_iv);
`ifdef UUT_RUN_CTRL_DEBUG_EN
    m_oh = {m_fin, !m_fin && m_age >= R + 1, !m_fin && m_age >= 1 && m_age <= R, !m_fin && m_age == 0};
    chk("debug_hi", debug_o[15:10], {m_oh, m_tmo, m_busy});
    if (m_oh[2]) chk("debug_cnt", debug_o[9:0], 10'(m_age - R - 1));
`endif
  end

  // one run; end_k = RUN cycle end_uut rises (-1 never), abort_k = RUN cycle rst is raised (-1 none)
  task automatic run(input logic [79:0] k, input logic [79:0] iv, input logic [31:0] to, input int end_k,
                     input bit early, input bit repulse, input int abort_k, input int exp_cyc, input bit exp_tmo);
    int exp_i;
    exp_i = exp_tmo ? R + 2 + exp_cyc : R + 3 + exp_cyc;
    @(negedge clk);
    start = 1; key_i = k; iv_i = iv; timeout_i = to; end_uut = early; blk_in = BASE;
    for (int i = 1; i < 3000; i++) begin
      @(negedge clk);
      start = repulse && i == 3;
      key_i = 80'({$urandom(), $urandom(), $urandom()});
      iv_i = 80'({$urandom(), $urandom(), $urandom()});
      timeout_i = $urandom_range(1, 20);
      blk_in = BASE ^ 64'(i);
      end_uut = early || (end_k >= 0 && i >= R + 2 + end_k);
      if (i == 1) chk("load_key", key_uut, k);
      if (i == R + 1) chk("hold_last_rstu", rst_uut, 1'b1);
      if (i == R + 2) chk("run0_rstu", rst_uut, 1'b0);
      if (abort_k >= 0 && i == R + 2 + abort_k) rst = 1;
      if (abort_k >= 0 && i == R + 3 + abort_k) begin
        chk("abort_busy", busy, 1'b0);
        chk("abort_done", done, 1'b0);
        chk("abort_rstu", rst_uut, 1'b1);
        chk("abort_key", key_uut, 80'h0);
        chk("abort_cycles", cycles_o, 32'h0);
        rst = 0;
        return;
      end
      if (done) begin
        chk("done_at", 32'(i), 32'(exp_i));
        chk("run_cycles", cycles_o, 32'(exp_cyc));
        chk("run_tmo", timeout_o, exp_tmo);
        chk("run_block", block_o, exp_tmo ? 64'h0 : BASE ^ 64'(exp_i - 1));
        end_uut = 0;
        return;
      end
    end
    chk("run_done_seen", done, 1'b1);
    end_uut = 0;
  endtask

  initial begin
    @(posedge clk);
    chk_en = 1;
    @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_rstu", rst_uut, 1'b1);
    chk("rst_cycles", cycles_o, 32'h0);
    chk("rst_key", key_uut, 80'h0);
    rst = 0;
    run(80'h1, 80'h2, 0, 1152, 0, 0, -1, 1152, 0);
    run(80'hAAAA, 80'hBBBB, 100, -1, 0, 0, -1, 100, 1);
    @(negedge clk);
    chk("t2_rstu_idle", rst_uut, 1'b1);
    run(80'h1234_5678, 80'h9ABC, 100, 99, 0, 0, -1, 99, 0);
    run(80'h55, 80'h66, 0, -1, 1, 1, -1, 0, 0);
    run(80'h77, 80'h88, 0, -1, 0, 0, 50, 0, 0);
    repeat (3) @(negedge clk);
    chk("post_abort_done", done, 1'b0);
    run(80'h99, 80'hAB, 0, 10, 0, 0, -1, 10, 0);
    run(80'hF00D, 80'hBEEF, 0, 5, 0, 0, -1, 5, 0);
    run(80'hCAFE, 80'hD00D, 1, -1, 0, 0, -1, 1, 1);
    run(80'h1357, 80'h2468, 7, 3, 0, 0, -1, 3, 0);
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
